// File: rtl/quant_result_packer.sv
// quant_result_packer: captures a tile of quantized lanes and streams it out as OUT_WIDTH-bit beats
module quant_result_packer #(
  parameter int QUANTIZER_SIZE     = 64,
  parameter int COMPUTE_DATA_WIDTH = 4,
  parameter int OUT_WIDTH          = 32,
  parameter int BEATS              = QUANTIZER_SIZE * COMPUTE_DATA_WIDTH / OUT_WIDTH,
  parameter int BW                 = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [COMPUTE_DATA_WIDTH-1:0] ins [QUANTIZER_SIZE],
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic        [OUT_WIDTH-1:0]          out_data,
  output logic                                 out_last,
  output logic        [BW-1:0]                 out_beat
`ifdef QUANT_PACKER_TILE_CNT_EN
  ,
  output logic        [15:0]                   tile_count
`endif
);
  localparam int TW = QUANTIZER_SIZE * COMPUTE_DATA_WIDTH;
  if (OUT_WIDTH % COMPUTE_DATA_WIDTH != 0 || TW % OUT_WIDTH != 0 || BEATS * OUT_WIDTH != TW) begin : g_bad_cfg
    $error("quant_result_packer: lanes must pack exactly into whole OUT_WIDTH beats");
  end
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [TW-1:0] tile_q, tile_d, tile_in;
  logic in_fire, out_fire;
  always_comb begin
    tile_in = '0;
    for (int k = 0; k < QUANTIZER_SIZE; k++) tile_in[k*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH] = ins[k];
  end
  assign out_valid = state_q == SEND;
  assign out_last  = out_valid && beat_q == BW'(BEATS - 1);
  assign out_beat  = beat_q;
  // Gating with rst_n keeps the input side closed while the block is held in reset.
  assign in_ready  = rst_n && (state_q == IDLE || (out_last && out_ready));
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  always_comb begin
    out_data = '0;
    for (int b = 0; b < BEATS; b++) if (beat_q == BW'(b)) out_data = tile_q[b*OUT_WIDTH +: OUT_WIDTH];
  end
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    tile_d  = in_fire ? tile_in : tile_q;
    if (in_fire) begin
      state_d = SEND;
      beat_d  = '0;
    end else if (out_fire) begin
      state_d = out_last ? IDLE : SEND;
      beat_d  = out_last ? '0 : beat_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      tile_q  <= tile_d;
    end
  end
`ifdef QUANT_PACKER_TILE_CNT_EN
  logic [15:0] tile_count_q, tile_count_d;
  assign tile_count_d = tile_count_q + 16'(out_fire && out_last);
  assign tile_count   = tile_count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tile_count_q <= '0;
    else tile_count_q <= tile_count_d;
  end
`endif
endmodule

// File: tb/tb_quant_result_packer.sv
// tb_quant_result_packer: directed self-checking bench for quant_result_packer
module tb_quant_result_packer;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_last;
  logic signed [3:0] ins [64];
  logic [31:0] out_data;
  logic [2:0] out_beat;
  int tests = 0, fails = 0;
`ifdef QUANT_PACKER_TILE_CNT_EN
  logic [15:0] tile_count;
`endif
  quant_result_packer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ins(ins),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_beat(out_beat)
`ifdef QUANT_PACKER_TILE_CNT_EN
    , .tile_count(tile_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fill(input logic [3:0] v, input bit ramp);
    for (int k = 0; k < 64; k++) ins[k] = ramp ? 4'(k % 16) : v;
  endtask
  task automatic capture();
    in_valid = 1;
    check("cap_ready", {31'd0, in_ready}, 1);
    tick();
    in_valid = 0;
  endtask
  initial begin
    int cyc, eb;
    fill(0, 1);
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_beat", {29'd0, out_beat}, 0);
    check("rst_out_last", {31'd0, out_last}, 0);
    tick();
    rst_n = 1;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 1);
    // ramp tile, consumer always ready
    out_ready = 1;
    capture();
    for (int b = 0; b < 8; b++) begin
      check("ramp_valid", {31'd0, out_valid}, 1);
      check("ramp_beat", {29'd0, out_beat}, 32'(b));
      check("ramp_data", out_data, b % 2 ? 32'hFEDCBA98 : 32'h76543210);
      check("ramp_last", {31'd0, out_last}, {31'd0, b == 7});
      tick();
    end
    check("ramp_idle_valid", {31'd0, out_valid}, 0);
    check("ramp_idle_ready", {31'd0, in_ready}, 1);
    // same tile with out_ready alternating 1/0
    capture();
    eb = 0;
    cyc = 0;
    while (eb < 8 && cyc < 40) begin
      out_ready = (cyc % 2) == 0;
      check("stall_beat", {29'd0, out_beat}, 32'(eb));
      check("stall_data", out_data, eb % 2 ? 32'hFEDCBA98 : 32'h76543210);
      check("stall_last", {31'd0, out_last}, {31'd0, eb == 7});
      if (out_ready) eb++;
      cyc++;
      tick();
    end
    check("stall_cycles", 32'(cyc), 15);
    check("stall_done", {31'd0, out_valid}, 0);
    // back-to-back tiles A then B
    out_ready = 1;
    fill(4'h1, 0);
    capture();
    in_valid = 1;
    fill(4'hF, 0);
    for (int i = 0; i < 16; i++) begin
      check("b2b_valid", {31'd0, out_valid}, 1);
      check("b2b_beat", {29'd0, out_beat}, 32'(i % 8));
      check("b2b_data", out_data, i < 8 ? 32'h11111111 : 32'hFFFFFFFF);
      if (i == 7) check("b2b_in_ready", {31'd0, in_ready}, 1);
      tick();
      if (i == 7) in_valid = 0;
    end
    check("b2b_end", {31'd0, out_valid}, 0);
    // ins changing during SEND must not disturb the captured tile
    fill(4'h1, 0);
    capture();
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 64; k++) ins[k] = 4'($urandom_range(0, 15));
      check("hold_data", out_data, 32'h11111111);
      tick();
    end
    // reset at beat 3
    fill(0, 1);
    capture();
    for (int b = 0; b < 3; b++) tick();
    check("mid_beat", {29'd0, out_beat}, 3);
    #2 rst_n = 0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 0);
    check("mid_rst_ready", {31'd0, in_ready}, 0);
    check("mid_rst_data", out_data, 0);
    tick();
    rst_n = 1;
    #1;
    check("mid_rel_ready", {31'd0, in_ready}, 1);
    for (int c = 0; c < 3; c++) begin
      check("mid_no_partial", {31'd0, out_valid}, 0);
      tick();
    end
    fill(4'hF, 0);
    capture();
    check("mid_new_beat", {29'd0, out_beat}, 0);
    check("mid_new_data", out_data, 32'hFFFFFFFF);
    for (int b = 0; b < 8; b++) tick();
    check("mid_new_done", {31'd0, out_valid}, 0);
`ifdef QUANT_PACKER_TILE_CNT_EN
    check("tile_count", {16'd0, tile_count}, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
